// File: rtl/fnn_layer_ctrl.sv
// -----------------------------------------------------------------------------
// fnn_layer_ctrl
//   Sequences one fully connected layer. An input activation vector arrives as
//   a valid/ready stream and is broadcast, registered, to every neuron. The
//   controller then waits for each neuron's outvalid pulse, captures the
//   neuron outputs, and serialises the results to the next layer as a
//   valid/ready stream with a last flag.
//
// Ports
//   clk, rst           clock; asynchronous active-high reset
//   in_data/valid/ready     input activation stream
//   neuron_in/_valid        registered broadcast to all neurons
//   neuron_out/_outvalid    packed neuron results and per-neuron pulses
//   out_data/valid/ready/last  result stream to the next layer
//   busy                    controller is not idle
//   err_timeout             sticky: WAIT expired before all neurons answered
//   err_spurious            sticky: neuron pulse seen in IDLE or DRAIN
//   err_clr                 synchronous clear of both sticky errors
// -----------------------------------------------------------------------------
module fnn_layer_ctrl #(
   parameter int numNeuron     = 30,
   parameter int numWeight     = 784,
   parameter int dataWidth     = 16,
   parameter int timeoutCycles = 64
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [dataWidth-1:0]           in_data,
   input  logic                           in_valid,
   output logic                           in_ready,
   output logic [dataWidth-1:0]           neuron_in,
   output logic                           neuron_in_valid,
   input  logic [numNeuron*dataWidth-1:0] neuron_out,
   input  logic [numNeuron-1:0]           neuron_outvalid,
   output logic [dataWidth-1:0]           out_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           out_last,
   output logic                           busy,
   output logic                           err_timeout,
   output logic                           err_spurious,
   input  logic                           err_clr
);

   localparam int CNT_W  = $clog2(numWeight + 1);
   localparam int WAIT_W = (timeoutCycles > 1) ? $clog2(timeoutCycles) : 1;
   localparam int IDX_W  = (numNeuron > 1) ? $clog2(numNeuron) : 1;

   typedef enum logic [1:0] {IDLE, FEED, WAIT, DRAIN} state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       in_cnt;
   logic [WAIT_W-1:0]      wait_cnt;
   logic [IDX_W-1:0]       idx;
   logic [numNeuron-1:0]   done;
   logic [dataWidth-1:0]   cap [numNeuron];

   logic xfer;
   logic capturing;
   logic all_done;
   logic timeout_evt;
   logic spurious_evt;
   logic drain_beat;
   logic drain_last;

   assign xfer         = in_valid & in_ready;
   assign capturing    = (state_q == FEED) || (state_q == WAIT);
   // Pulses arriving in the same cycle count toward completion.
   assign all_done     = &(done | neuron_outvalid);
   assign timeout_evt  = (state_q == WAIT) && !all_done &&
                         (wait_cnt == WAIT_W'(timeoutCycles - 1));
   assign spurious_evt = ((state_q == IDLE) || (state_q == DRAIN)) && (|neuron_outvalid);
   assign drain_beat   = (state_q == DRAIN) && out_ready;
   assign drain_last   = drain_beat && (idx == IDX_W'(numNeuron - 1));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state and stream-side outputs
   // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      busy      = 1'b1;
      out_valid = 1'b0;
      out_last  = 1'b0;
      out_data  = '0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (xfer) state_d = (numWeight == 1) ? WAIT : FEED;
         end
         FEED: begin
            in_ready = 1'b1;
            if (xfer && (in_cnt == CNT_W'(numWeight - 1))) state_d = WAIT;
         end
         WAIT: begin
            if (all_done || timeout_evt) state_d = DRAIN;
         end
         DRAIN: begin
            out_valid = 1'b1;
            out_last  = (idx == IDX_W'(numNeuron - 1));
            // Neurons that never answered drain as zero.
            out_data  = done[idx] ? cap[idx] : '0;
            if (drain_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Broadcast register and sequencing counters
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         neuron_in       <= '0;
         neuron_in_valid <= 1'b0;
         in_cnt          <= '0;
         wait_cnt        <= '0;
         idx             <= '0;
      end else begin
         neuron_in_valid <= xfer;
         if (xfer) begin
            neuron_in <= in_data;
            in_cnt    <= (state_q == IDLE) ? CNT_W'(1) : in_cnt + CNT_W'(1);
         end
         if (state_q == WAIT) wait_cnt <= wait_cnt + WAIT_W'(1);
         if (drain_beat)      idx      <= idx + IDX_W'(1);
         if (drain_last) begin
            in_cnt   <= '0;
            wait_cnt <= '0;
            idx      <= '0;
         end
      end
   end

   // Capture of neuron results
   // NOTE: the capture array is a small register file, not RAM, so it is reset along with the done mask.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done <= '0;
         for (int k = 0; k < numNeuron; k++) cap[k] <= '0;
      end else if (drain_last) begin
         done <= '0;
      end else if (capturing) begin
         for (int k = 0; k < numNeuron; k++) begin
            if (neuron_outvalid[k]) begin
               cap[k]  <= neuron_out[k*dataWidth +: dataWidth];
               done[k] <= 1'b1;
            end
         end
      end
   end

   // Sticky errors: a set event in the same cycle wins over err_clr.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_timeout  <= 1'b0;
         err_spurious <= 1'b0;
      end else begin
         if (timeout_evt)  err_timeout <= 1'b1;
         else if (err_clr) err_timeout <= 1'b0;
         if (spurious_evt) err_spurious <= 1'b1;
         else if (err_clr) err_spurious <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fnn_layer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fnn_layer_ctrl
//   Scoreboard bench for fnn_layer_ctrl (3 neurons, 4 weights, timeout 8).
//   Drivers push expected broadcast values and expected result beats into
//   queues; a negedge monitor pops and compares whenever the DUT presents
//   a beat. Neuron results are modelled as a per-neuron "latest value seen
//   while the layer was collecting" table.
// -----------------------------------------------------------------------------
module tb_fnn_layer_ctrl;

   localparam int NN = 3;
   localparam int NW = 4;
   localparam int DW = 16;
   localparam int TO = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [DW-1:0]     in_data;
   logic              in_valid;
   logic              in_ready;
   logic [DW-1:0]     neuron_in;
   logic              neuron_in_valid;
   logic [NN*DW-1:0]  neuron_out;
   logic [NN-1:0]     neuron_outvalid;
   logic [DW-1:0]     out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;
   logic              busy;
   logic              err_timeout;
   logic              err_spurious;
   logic              err_clr;

   fnn_layer_ctrl #(
      .numNeuron(NN), .numWeight(NW), .dataWidth(DW), .timeoutCycles(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .neuron_in(neuron_in), .neuron_in_valid(neuron_in_valid),
      .neuron_out(neuron_out), .neuron_outvalid(neuron_outvalid),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy),
      .err_timeout(err_timeout), .err_spurious(err_spurious), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   int            checks   = 0;
   int            failures = 0;
   logic [DW-1:0] exp_bcast [$];
   beat_t         exp_out   [$];

   // Reference model of the neuron results for the current vector
   logic [DW-1:0] model_cap  [NN];
   logic          model_done [NN];
   logic [DW-1:0] vec [NW];
   logic [DW-1:0] pv  [NN];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor ----------------
   logic          sent_q = 1'b0;
   logic          stall_pend = 1'b0;
   logic [DW-1:0] held = '0;
   logic [DW-1:0] eb;
   beat_t         eo;

   always @(posedge clk) sent_q <= in_valid;

   always @(negedge clk) begin
      if (!rst) begin
         check("bcast_valid", neuron_in_valid, sent_q);
         if (neuron_in_valid) begin
            checks++;
            if (exp_bcast.size() == 0) begin
               failures++;
               $display("FAIL bcast_unexpected: got 0x%0h expected none", neuron_in);
            end else begin
               eb = exp_bcast.pop_front();
               check("bcast_data", neuron_in, eb);
            end
         end
         if (stall_pend && out_valid) check("out_hold", out_data, held);
         if (out_valid && out_ready) begin
            checks++;
            if (exp_out.size() == 0) begin
               failures++;
               $display("FAIL out_unexpected: got 0x%0h expected none", out_data);
            end else begin
               eo = exp_out.pop_front();
               check("out_data", out_data, eo.data);
               check("out_last", out_last, eo.last);
            end
         end
         stall_pend = out_valid && !out_ready;
         held       = out_data;
      end
   end

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int k = 0; k < NN; k++) begin
         model_cap[k]  = '0;
         model_done[k] = 1'b0;
      end
   endtask

   task automatic push_expected();
      beat_t b;
      for (int k = 0; k < NN; k++) begin
         b.data = model_done[k] ? model_cap[k] : '0;
         b.last = (k == NN - 1);
         exp_out.push_back(b);
      end
   endtask

   task automatic random_vec();
      for (int i = 0; i < NW; i++) vec[i] = DW'($urandom);
   endtask

   // Sends vec[] as one vector; pat_len>0 selects a fixed valid pattern.
   task automatic send_vec(input int gap_pct, input logic [7:0] pat, input int pat_len);
      int   i;
      int   cyc;
      logic go;
      i   = 0;
      cyc = 0;
      while (i < NW && cyc < 64) begin
         if (pat_len > 0) go = pat[cyc % 8];
         else             go = ($urandom_range(0, 99) >= gap_pct);
         if (go) begin
            check("in_ready_feed", in_ready, 1);
            in_valid = 1'b1;
            in_data  = vec[i];
            exp_bcast.push_back(vec[i]);
            i++;
         end else begin
            in_valid = 1'b0;
            in_data  = DW'($urandom);
         end
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      check("in_ready_wait", in_ready, 0);
      check("busy_wait", busy, 1);
   endtask

   // One cycle of neuron pulses; cap_en says whether the layer is collecting.
   task automatic pulse(input logic [NN-1:0] mask, input logic cap_en);
      for (int k = 0; k < NN; k++) neuron_out[k*DW +: DW] = pv[k];
      neuron_outvalid = mask;
      if (cap_en) begin
         for (int k = 0; k < NN; k++) begin
            if (mask[k]) begin
               model_cap[k]  = pv[k];
               model_done[k] = 1'b1;
            end
         end
      end
      tick();
      neuron_outvalid = '0;
   endtask

   task automatic respond_all();
      logic [NN-1:0] mask;
      logic          all;
      int            c;
      c   = 0;
      all = 1'b0;
      while (!all) begin
         mask = NN'($urandom_range(0, (1 << NN) - 1));
         if (c >= 3) begin
            for (int k = 0; k < NN; k++) if (!model_done[k]) mask[k] = 1'b1;
         end
         for (int k = 0; k < NN; k++) pv[k] = DW'($urandom);
         pulse(mask, 1'b1);
         all = 1'b1;
         for (int k = 0; k < NN; k++) if (!model_done[k]) all = 1'b0;
         c++;
      end
   endtask

   // mode 0: always ready; 1: stall 3 cycles then toggle; 2: random
   task automatic drain(input int mode);
      int n;
      bit fin;
      n   = 0;
      fin = 1'b0;
      while (!fin && n < 300) begin
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (n < 3) ? 1'b0 : n[0];
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         fin = out_valid && out_ready && out_last;
         tick();
         n++;
      end
      out_ready = 1'b0;
      checks++;
      if (!fin) begin
         failures++;
         $display("FAIL drain_done: got no last beat within %0d cycles", n);
      end
      check("idle_busy", busy, 0);
      check("idle_in_ready", in_ready, 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst             = 1'b1;
      in_data         = '0;
      in_valid        = 1'b0;
      neuron_out      = '0;
      neuron_outvalid = '0;
      out_ready       = 1'b0;
      err_clr         = 1'b0;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_niv", neuron_in_valid, 0);
      check("rst_neuron_in", neuron_in, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_last", out_last, 0);
      check("rst_err_to", err_timeout, 0);
      check("rst_err_sp", err_spurious, 0);
      rst = 1'b0;
      tick();

      // Back-to-back 1,2,3,4 then neuron 2, then {0,1} together
      for (int i = 0; i < NW; i++) vec[i] = DW'(i + 1);
      model_clear();
      send_vec(0, 8'h00, 0);
      pv[0] = 16'h0011; pv[1] = 16'h0022; pv[2] = 16'h0033;
      pulse(3'b100, 1'b1);
      pulse(3'b011, 1'b1);
      push_expected();
      drain(0);

      // Valid gaps 1,0,1,1,0,1; drain with stalls
      random_vec();
      model_clear();
      send_vec(0, 8'b0010_1101, 6);
      respond_all();
      push_expected();
      drain(1);

      // Timeout: only neuron 0 answers
      random_vec();
      model_clear();
      send_vec(0, 8'h00, 0);
      pv[0] = 16'h7FFF;
      pulse(3'b001, 1'b1);
      push_expected();
      repeat (6) tick();
      check("to_not_yet_valid", out_valid, 0);
      check("to_not_yet_err", err_timeout, 0);
      tick();
      check("to_err_set", err_timeout, 1);
      check("to_drain_valid", out_valid, 1);
      drain(2);
      check("to_err_sticky", err_timeout, 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("to_err_cleared", err_timeout, 0);

      // Spurious pulse in IDLE: flagged, not captured; set wins over clear
      pv[1] = 16'h5555;
      pulse(3'b010, 1'b0);
      check("sp_set", err_spurious, 1);
      err_clr = 1'b1;
      pulse(3'b010, 1'b0);
      err_clr = 1'b0;
      check("sp_set_wins", err_spurious, 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("sp_cleared", err_spurious, 0);
      random_vec();
      model_clear();
      send_vec(20, 8'h00, 0);
      pv[0] = DW'($urandom); pv[2] = DW'($urandom);
      pulse(3'b101, 1'b1);
      push_expected();
      drain(2);
      check("sp_vec_timeout", err_timeout, 1);
      check("sp_vec_no_spur", err_spurious, 0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;

      // Reset in the middle of FEED
      random_vec();
      in_valid = 1'b1; in_data = vec[0]; exp_bcast.push_back(vec[0]);
      tick();
      in_data = vec[1]; exp_bcast.push_back(vec[1]);
      tick();
      in_valid = 1'b0;
      tick();
      check("feed_busy", busy, 1);
      rst = 1'b1;
      #1;
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_niv", neuron_in_valid, 0);
      check("mid_rst_neuron_in", neuron_in, 0);
      check("mid_rst_out_valid", out_valid, 0);
      tick();
      rst = 1'b0;
      tick();

      // Randomised vectors (the first one follows the mid-FEED reset)
      for (int v = 0; v < 6; v++) begin
         random_vec();
         model_clear();
         send_vec(30, 8'h00, 0);
         respond_all();
         push_expected();
         drain(2);
      end
      check("final_err_to", err_timeout, 0);

      repeat (3) tick();
      check("bcast_q_empty", exp_bcast.size(), 0);
      check("out_q_empty", exp_out.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/fnn_layer_ctrl.md
Name: fnn_layer_ctrl

Overview:
- Sequences one fully connected layer of neurons.
- Accepts an input activation vector as a valid/ready stream and broadcasts it, registered, to every neuron of the layer.
- Waits for every neuron's outvalid pulse, captures each neuron output, then serialises the numNeuron results to the next layer as a valid/ready stream with a last flag.
- Sits between the layer's input buffer and the next layer; one instance per layer.

Parameters:
- numNeuron, 30, neurons in this layer; also the output vector length.
- numWeight, 784, input activations per vector (= weights per neuron).
- dataWidth, 16, activation width.
- timeoutCycles, 64, maximum WAIT-state cycles before forcing a drain.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_data  in  dataWidth  input activation.
- in_valid  in  1  in_data valid.
- in_ready  out  1  ctrl accepts in_data.
- neuron_in  out  dataWidth  broadcast activation to all neurons (myinput).
- neuron_in_valid  out  1  broadcast valid (myinputValid).
- neuron_out  in  numNeuron*dataWidth  packed neuron outputs; neuron k at [k*dataWidth +: dataWidth].
- neuron_outvalid  in  numNeuron  per-neuron outvalid pulses.
- out_data  out  dataWidth  result activation.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_last  out  1  marks neuron numNeuron-1 result.
- busy  out  1  state != IDLE.
- err_timeout  out  1  sticky: WAIT timed out.
- err_spurious  out  1  sticky: outvalid seen in IDLE or DRAIN.
- err_clr  in  1  synchronous clear of both sticky errors.

Behaviour:
- Reset (async, any state): state=IDLE. Reset value 0 for every output except in_ready=1 (IDLE value). Counters, done mask and capture registers are cleared.
- States: IDLE, FEED, WAIT, DRAIN.
- Handshake: a transfer occurs when in_valid&in_ready are high on a rising edge.
- Broadcast:
  - neuron_in and neuron_in_valid are registered.
  - On a transfer, neuron_in<=in_data and neuron_in_valid<=1 on the next cycle; otherwise neuron_in_valid<=0 and neuron_in holds.
  - Latency is exactly 1 cycle. Gaps in in_valid produce gaps in neuron_in_valid and are legal.
- in_ready=1 in IDLE and FEED, 0 in WAIT and DRAIN (combinational from state).
- IDLE: a transfer sets in_cnt=1 and moves to FEED. If numWeight==1, it moves directly to WAIT.
- FEED: each transfer increments in_cnt. The transfer that makes in_cnt==numWeight moves to WAIT with in_ready low the next cycle. in_cnt width is $clog2(numWeight+1).
- Capture, in FEED and WAIT: for each k with neuron_outvalid[k]=1, cap[k]<=neuron_out slice k and done[k]<=1. Multiple bits in the same cycle are all captured. A repeat pulse overwrites cap[k].
- WAIT:
  - wait_cnt increments each cycle.
  - When done is all-ones (including bits set that same cycle) -> DRAIN with idx=0.
  - If wait_cnt reaches timeoutCycles-1 without completion -> err_timeout<=1 and DRAIN. Uncaptured neurons drain as 0.
- DRAIN:
  - out_valid=1, out_data=cap[idx], out_last=(idx==numNeuron-1).
  - idx advances on out_valid&out_ready. out_data/out_last hold stable while out_ready=0.
  - The handshake with out_last -> IDLE. done, idx, in_cnt and wait_cnt clear on that edge.
- err_spurious: set on any neuron_outvalid bit in IDLE or DRAIN. These pulses are otherwise ignored (no capture).
- err_clr: clears both sticky errors that cycle. A set event in the same cycle wins over err_clr.
- No new input is accepted until DRAIN completes. The first transfer of the next vector can occur the cycle after returning to IDLE.

Test Plan:
- numWeight=4, numNeuron=3: 4 back-to-back transfers of 1,2,3,4 -> neuron_in_valid high cycles 1..4 carrying 1..4. in_ready low from cycle 4. busy=1.
- Same config, in_valid gaps (pattern 1,0,1,1,0,1) -> neuron_in_valid follows the pattern delayed 1 cycle. WAIT entered only after the 4th transfer.
- In WAIT, outvalid bits 2, then {0,1} together, with outputs 0x0011/0x0022/0x0033 -> DRAIN emits 0x0011, 0x0022, 0x0033. out_last only on the third. Returns to IDLE.
- DRAIN with out_ready low 3 cycles, then toggling -> out_data stable while stalled. No beats lost or duplicated.
- timeoutCycles=8, only neuron 0 responds (0x7FFF) -> err_timeout=1 after 8 WAIT cycles. Drain yields 0x7FFF,0,0. err_clr clears it.
- outvalid pulse in IDLE -> err_spurious=1, no capture. Assert rst mid-FEED -> all outputs immediately 0, in_ready=1. The next vector processes normally.
